kernel_stream_engine: RTL and testbench

Streaming 3x3 convolution engine that succeeds the combinational single-window kernel unit. Accepts a raster-order pixel stream over a valid/ready handshake and builds the 3x3 window internally from two line buffers. Applies a frame-latched kernel mode, saturates, and emits one output pixel per interior window on a valid/ready output stream. Sits in the EXE stage between the pixel cache/memory reader and the write-back path. Pixel width and frame geometry are parametrised.

---
 rtl/kernel_pkg.sv | 36 +++
 rtl/kernel_mac.sv | 58 +++++
 rtl/kernel_stream_engine.sv | 127 ++++++++++++
 tb/tb_kernel_stream_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// Shared types and helpers for the streaming 3x3 kernel engine.
package kernel_pkg;

  // Kernel operation, latched once per frame.
  typedef enum logic [1:0] {
    K_IDENT  = 2'b00,
    K_BLUR   = 2'b01,
    K_SHARP  = 2'b10,
    K_OSHARP = 2'b11
  } kmode_t;

  // Five guard bits cover 9 * max pixel plus a sign bit.
  localparam int ACC_GUARD = 5;

  function automatic int acc_width(input int pix_w);
    return pix_w + ACC_GUARD;
  endfunction

  // Window geometry: taps stored row-major, tap 0 is top-left.
  localparam int WIN_DIM    = 3;
  localparam int WIN_TAPS   = WIN_DIM * WIN_DIM;
  localparam int TAP_N      = 1;
  localparam int TAP_W      = 3;
  localparam int WIN_CENTRE = 4;
  localparam int TAP_E      = 5;
  localparam int TAP_S      = 7;

  function automatic int tap(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

  // Window of default-width (8-bit) pixels; parametrised modules use the
  // same row-major packed shape at their own PIX_W.
  typedef logic [WIN_TAPS-1:0][7:0] window_t;

endpackage

// File: rtl/kernel_mac.sv
// Combinational 3x3 window evaluation: applies the selected kernel and
// clamps the signed result into the unsigned pixel range.
module kernel_mac
  import kernel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [WIN_TAPS-1:0][PIX_W-1:0] win,
  input  logic [1:0]                     mode,
  output logic [PIX_W-1:0]               pix
);

  localparam int ACC_W = acc_width(PIX_W);
  localparam logic signed [ACC_W-1:0] PIX_MAX = {{(ACC_W - PIX_W){1'b0}}, {PIX_W{1'b1}}};

  function automatic logic signed [ACC_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(ACC_W - PIX_W){1'b0}}, p});
  endfunction

  logic signed [ACC_W-1:0] sum9;
  logic signed [ACC_W-1:0] cross_sum;
  logic signed [ACC_W-1:0] ctr;
  logic signed [ACC_W-1:0] acc;

  // Partial sums shared by all kernels.
  always_comb begin
    sum9 = '0;
    for (int i = 0; i < WIN_TAPS; i++) begin
      sum9 = sum9 + ext(win[i]);
    end
    cross_sum = ext(win[TAP_N]) + ext(win[TAP_S]) + ext(win[TAP_E]) + ext(win[TAP_W]);
    ctr       = ext(win[WIN_CENTRE]);
  end

  // Kernel select; multiplies by 5 and 9 are done as shift-and-add.
  always_comb begin
    acc = ctr;
    case (kmode_t'(mode))
      K_IDENT:  acc = ctr;
      K_BLUR:   acc = sum9 >>> 3;
      K_SHARP:  acc = (ctr <<< 2) + ctr - cross_sum;
      K_OSHARP: acc = (ctr <<< 3) + ctr - (sum9 - ctr);
      default:  acc = ctr;
    endcase
  end

  // Clamp into [0, 2^PIX_W - 1].
  always_comb begin
    if (acc < 0) begin
      pix = '0;
    end else if (acc > PIX_MAX) begin
      pix = '1;
    end else begin
      pix = acc[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/kernel_stream_engine.sv
// Streaming 3x3 convolution engine: raster pixels in, one saturated pixel
// out per interior window. Two line buffers rebuild the window on the fly;
// stage 1 is the window register, stage 2 the output register.
module kernel_stream_engine
  import kernel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ksel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  kmode_t        mode_reg;

  logic [PIX_W-1:0] lb0_mem [IMG_W];
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [WIN_TAPS-1:0][PIX_W-1:0] win_reg;

  logic s1_valid_reg;
  logic s1_last_reg;

  logic             out_valid_reg;
  logic             out_last_reg;
  logic [PIX_W-1:0] out_pix_reg;

  logic             en;
  logic             accept;
  logic             col_end;
  logic             row_end;
  logic [PIX_W-1:0] mac_pix;

  // Whole pipeline moves only when the output register is empty or draining.
  assign en       = !out_valid_reg || out_ready;
  assign accept   = in_valid && en;
  assign in_ready = en;
  assign col_end  = (col_reg == COL_LAST);
  assign row_end  = (row_reg == ROW_LAST);

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_pix   = out_pix_reg;

  // Raster position and per-frame kernel mode, latched on the frame's first pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg  <= '0;
      row_reg  <= '0;
      mode_reg <= K_IDENT;
    end else if (accept) begin
      if (col_reg == '0 && row_reg == '0) begin
        mode_reg <= kmode_t'(ksel);
      end
      if (col_end) begin
        col_reg <= '0;
        row_reg <= row_end ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Line buffers and sliding window; contents are don't-care until valid is flagged.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        win_reg[tap(r, 0)] <= win_reg[tap(r, 1)];
        win_reg[tap(r, 1)] <= win_reg[tap(r, 2)];
      end
      win_reg[tap(0, 2)] <= lb1_mem[col_reg];
      win_reg[tap(1, 2)] <= lb0_mem[col_reg];
      win_reg[tap(2, 2)] <= in_pix;
      lb1_mem[col_reg]   <= lb0_mem[col_reg];
      lb0_mem[col_reg]   <= in_pix;
    end
  end

  // Stage-1 flags: a window is complete once two rows and two columns are behind it.
  // With no accept the stage empties, so stage 2 never sees the same window twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
      s1_last_reg  <= accept && row_end && col_end;
    end
  end

  kernel_mac #(
    .PIX_W (PIX_W)
  ) u_mac (
    .win  (win_reg),
    .mode (mode_reg),
    .pix  (mac_pix)
  );

  // Stage-2 output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_pix_reg   <= '0;
    end else if (en) begin
      out_valid_reg <= s1_valid_reg;
      out_last_reg  <= s1_last_reg;
      out_pix_reg   <= mac_pix;
    end
  end

endmodule

// File: tb/tb_kernel_stream_engine.sv
// Self-checking bench for kernel_stream_engine on a 5x5 frame.
module tb_kernel_stream_engine;

  localparam int PW   = 8;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    ksel;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pix;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pix;
  logic          out_last;

  kernel_stream_engine #(
    .PIX_W (PW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ksel      (ksel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic [1:0] ks;
  } beat_t;

  typedef struct {
    int pix;
    bit last;
  } exp_t;

  beat_t in_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    out_count = 0;
  bit    gaps = 0;
  bit    bp = 0;
  int    fr[NPIX];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Reference: evaluate every interior centre directly from the 2-D frame.
  task automatic add_frame(input int f[NPIX], input logic [1:0] ks_first,
                           input logic [1:0] ks_rest, input int toggle_at);
    int    mode;
    exp_t  e;
    beat_t b;
    for (int p = 0; p < NPIX; p++) begin
      b.pix = f[p][7:0];
      b.ks  = (p < toggle_at) ? ks_first : ks_rest;
      in_q.push_back(b);
    end
    mode = int'(ks_first);
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        int ctr, cross_s, all9, v;
        ctr     = f[r*W + c];
        cross_s = f[(r-1)*W + c] + f[(r+1)*W + c] + f[r*W + c - 1] + f[r*W + c + 1];
        all9    = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            all9 += f[(r+dr)*W + c + dc];
        case (mode)
          0: v = ctr;
          1: v = all9 / 8;
          2: v = 5 * ctr - cross_s;
          default: v = 9 * ctr - (all9 - ctr);
        endcase
        e.pix  = clamp(v);
        e.last = (r == H - 2) && (c == W - 2);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_pixels(input int f[NPIX], input int n, input logic [1:0] ks);
    beat_t b;
    for (int p = 0; p < n; p++) begin
      b.pix = f[p][7:0];
      b.ks  = ks;
      in_q.push_back(b);
    end
  endtask

  task automatic rand_frame();
    for (int p = 0; p < NPIX; p++) fr[p] = $urandom_range(0, 255);
  endtask

  // Drive queued pixels, consume outputs, compare against the reference queue.
  task automatic run(input int budget);
    int   cyc = 0;
    bit   acc_prev = 0;
    exp_t e;
    while ((in_q.size() > 0 || exp_q.size() > 0 || in_valid) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (acc_prev) in_valid = 1'b0;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!in_valid) begin
        if (in_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          in_valid = 1'b1;
          in_pix   = in_q[0].pix;
          ksel     = in_q[0].ks;
        end else begin
          ksel = 2'($urandom_range(0, 3));
        end
      end
      #1;
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      else                         check("free_in_ready", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          out_count++;
          $display("OUT %0d pix=%0d exp=%0d last=%0d", out_count, out_pix, e.pix, out_last);
          check("out_pix", 32'(out_pix), 32'(e.pix));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
      acc_prev = in_valid && in_ready;
      if (acc_prev) void'(in_q.pop_front());
    end
    check("run_pending", 32'(in_q.size() + exp_q.size()), 32'd0);
    in_q.delete();
    exp_q.delete();
    in_valid = 1'b0;
  endtask

  // After the last output has been taken, no further output may appear.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("drain_no_out", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ksel      = 2'b00;
    in_valid  = 1'b0;
    in_pix    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Constant 100, blur -> 112 everywhere.
    for (int p = 0; p < NPIX; p++) fr[p] = 100;
    add_frame(fr, 2'b01, 2'b01, NPIX);
    run(400);
    drain(3);

    // Constant 80, sharpen -> 80 everywhere.
    for (int p = 0; p < NPIX; p++) fr[p] = 80;
    add_frame(fr, 2'b10, 2'b10, NPIX);
    run(400);

    // Ramp, identity -> interior centre values 6..18.
    for (int p = 0; p < NPIX; p++) fr[p] = p;
    add_frame(fr, 2'b00, 2'b00, NPIX);
    run(400);

    // Over-sharpen saturation both ways.
    for (int p = 0; p < NPIX; p++) fr[p] = 0;
    fr[2*W + 2] = 255;
    add_frame(fr, 2'b11, 2'b11, NPIX);
    run(400);
    for (int p = 0; p < NPIX; p++) fr[p] = 255;
    fr[2*W + 2] = 0;
    add_frame(fr, 2'b11, 2'b11, NPIX);
    run(400);
    drain(3);

    // Mode change mid-frame is ignored until the next frame.
    rand_frame();
    add_frame(fr, 2'b01, 2'b10, 7);
    rand_frame();
    add_frame(fr, 2'b10, 2'b01, 1);
    run(800);

    // Back-to-back random frames with input gaps and output backpressure.
    gaps = 1'b1;
    bp   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_frame();
      add_frame(fr, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1);
    end
    run(4000);
    drain(3);

    // Abandon a frame after 12 pixels, then a fresh frame must be complete.
    gaps = 1'b0;
    bp   = 1'b0;
    rand_frame();
    push_pixels(fr, 12, 2'b11);
    run(200);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    out_count = 0;
    gaps = 1'b1;
    bp   = 1'b1;
    rand_frame();
    add_frame(fr, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1);
    run(1500);
    check("fresh_frame_count", 32'(out_count), 32'((W - 2) * (H - 2)));
    drain(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
